div_seq: RTL and testbench
==========================

Name: div_seq

Overview:
- Multi-cycle signed/unsigned 32-bit divide sequencer serving the EX stage for DIV/DIVU.
- EX raises a start request with the operands. The block iterates radix-2 restoring division, one quotient bit per cycle, and returns {remainder, quotient} for HI/LO.
- While the divide is in flight it drives a stall request to pipeline control.

Parameters:
- DATA_W, 32, operand width (quotient and remainder are each DATA_W bits).
- CNT_W, 6, iteration counter width (must hold the value DATA_W).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- signed_div_i  in  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled at start.
- opdata1_i  in  DATA_W  dividend; sampled at start.
- opdata2_i  in  DATA_W  divisor; sampled at start.
- start_i  in  1  divide request from EX; held high until ready_o is seen.
- annul_i  in  1  cancel (flush or exception in delay slot); aborts any divide in progress.
- result_o  out  2*DATA_W  {remainder[63:32], quotient[31:0]}; registered.
- ready_o  out  1  result valid; registered.
- stallreq_o  out  1  pipeline stall request; combinational.

Behaviour:
- Reset (rst=0, asynchronous): state=FREE, cnt=0, result_o=0, ready_o=0, internal dividend/divisor registers cleared. Reset asserted mid-divide discards the operation.
- States: FREE, BY_ZERO, ON, END (2-bit encoding).
- FREE:
  - if start_i=1 and annul_i=0: if opdata2_i=0, go to BY_ZERO.
  - Otherwise latch operands into ON with cnt=0. Operands are latched as magnitudes (two's-complement negate of negative operands) when signed_div_i=1.
  - Also latch the quotient sign (opdata1 sign XOR opdata2 sign) and the remainder sign (opdata1 sign).
  - Otherwise hold, with ready_o=0 and result_o=0.
- BY_ZERO: next edge goes to END with result_o=0 and ready_o=1.
- ON:
  - annul_i=1: go to FREE immediately; ready_o stays 0 and result_o stays 0.
  - Otherwise, while cnt<DATA_W: one shift-subtract step per edge, cnt++.
  - When cnt=DATA_W: apply sign fix-ups (negate quotient if its sign bit is set; negate remainder if the dividend was negative), load result_o, set ready_o=1, go to END.
  - start_i deasserting during ON is ignored; only annul_i cancels.
- END: hold result_o and ready_o=1 while start_i=1. When start_i=0, go to FREE with ready_o=0 and result_o=0. Holding start_i high never re-triggers a divide.
- Latency: start sampled at edge E0; iterations on E1..E32; ready_o=1 after E33. Divide by zero: ready_o=1 after E1.
- stallreq_o = (FREE & start_i & ~annul_i) | ON | BY_ZERO. It is 0 in END, so EX advances in the cycle ready_o is high.
- Signed INT_MIN / -1 yields quotient 0x80000000, remainder 0. This is the natural magnitude-arithmetic result, so no trap or special case is needed.
- Width rules:
  - Step compares {partial_rem[DATA_W-1:0], next dividend bit} against the divisor using a DATA_W+1-bit subtract.
  - The subtract's carry/borrow selects the quotient bit.

Optional Feature:
- DIV_ZERO_SHORTCUT_EN.
- Defined: in FREE, a start with opdata1_i=0 and opdata2_i!=0 goes to BY_ZERO, giving result 0 with ready_o after E1.
- Undefined: a zero dividend runs all 32 iterations (result still 0, ready after E33).
- Divide-by-zero handling is identical in both builds.

Decomposition:
- defines.v (shared):
  - state encodings DivFree 2'b00, DivByZero 2'b01, DivOn 2'b10, DivEnd 2'b11.
  - DivStart / DivStop, DivResultReady / DivResultNotReady.
  - ZeroWord, DoubleRegBus width macro.
  - New EX aluop codes EXE_DIV_OP / EXE_DIVU_OP.
- One sub-module: div_step, purely combinational. Inputs: partial remainder, divisor, next dividend bit. Outputs: new partial remainder and quotient bit. div_seq owns the FSM, counter and sign handling.

Test Plan:
- Unsigned 100 / 7, start held high → ready_o=1 after exactly 33 edges; result_o = {0x00000002, 0x0000000E}; stallreq_o=1 on cycles E0..E32, 0 at E33.
- Signed -7 / 2 (0xFFFFFFF9, 0x00000002) → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF.
- Divide by zero, 0x12345678 / 0 → ready_o after 1 edge (BY_ZERO → END); result_o=0.
- annul_i pulsed at iteration 10 → FREE next edge, ready_o never rises. A fresh start of 9/3 afterwards returns {0, 3}.
- Signed INT_MIN / -1 → quotient 0x80000000, remainder 0. Unsigned 0xFFFFFFFF / 1 → quotient 0xFFFFFFFF, remainder 0.
- rst low asynchronously mid-ON (no clock edge) → result_o=0, ready_o=0, stallreq_o=0 immediately. After release with start_i=0, the block sits in FREE; holding start_i in END keeps ready_o=1 without a restart.

Source files
------------

// File: rtl/div_seq_pkg.sv
// Shared types and constants for the multi-cycle divide sequencer.
// Optional build macro: DIV_ZERO_SHORTCUT_EN.
package div_seq_pkg;

  localparam int DIV_DATA_W = 32;
  localparam int DIV_CNT_W  = 6;
  localparam int DOUBLE_REG_W = 2 * DIV_DATA_W;

  typedef enum logic [1:0] {
    DIV_FREE    = 2'b00,
    DIV_BY_ZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_e;

  localparam logic DIV_START = 1'b1;
  localparam logic DIV_STOP  = 1'b0;

  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;

  localparam logic [DIV_DATA_W-1:0] ZERO_WORD = '0;

  localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division step.
// Purely combinational: shift in a dividend bit, trial-subtract divisor.
module div_step
  import div_seq_pkg::*;
#(
  parameter int DATA_W = DIV_DATA_W
) (
  input  logic [DATA_W-1:0] rem_i,
  input  logic [DATA_W-1:0] divisor_i,
  input  logic              bit_i,
  output logic [DATA_W-1:0] rem_o,
  output logic              q_o
);

  logic [DATA_W:0] trial;
  logic [DATA_W:0] diff;
  logic            borrow;
  logic            unused_msb;

  // Trial subtract; the borrow out decides the quotient bit.
  always_comb begin
    trial            = {rem_i, bit_i};
    {borrow, diff}   = {1'b0, trial} - {2'b00, divisor_i};
    q_o              = ~borrow;
    rem_o            = q_o ? diff[DATA_W-1:0] : trial[DATA_W-1:0];
    unused_msb       = diff[DATA_W];
  end

endmodule

// File: rtl/div_seq.sv
// Sequential signed/unsigned divider for DIV/DIVU, one bit per cycle.
// Optional build macro: DIV_ZERO_SHORTCUT_EN (zero dividend finishes early).
module div_seq
  import div_seq_pkg::*;
#(
  parameter int DATA_W = DIV_DATA_W,
  parameter int CNT_W  = DIV_CNT_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                signed_div_i,
  input  logic [DATA_W-1:0]   opdata1_i,
  input  logic [DATA_W-1:0]   opdata2_i,
  input  logic                start_i,
  input  logic                annul_i,
  output logic [2*DATA_W-1:0] result_o,
  output logic                ready_o,
  output logic                stallreq_o
);

  div_state_e state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   dvd_q, dvd_d;
  logic [DATA_W-1:0]   dvs_q, dvs_d;
  logic [DATA_W-1:0]   rem_q, rem_d;
  logic                negq_q, negq_d;
  logic                negr_q, negr_d;
  logic [2*DATA_W-1:0] result_q, result_d;
  logic                ready_q, ready_d;

  logic [DATA_W-1:0] step_rem;
  logic              step_q;
  logic              zero_go;
  logic              neg1;
  logic              neg2;

  function automatic logic [DATA_W-1:0] neg_if(
    input logic n, input logic [DATA_W-1:0] x);
    return n ? (~x + 1'b1) : x;
  endfunction

  div_step #(.DATA_W(DATA_W)) u_step (
    .rem_i     (rem_q),
    .divisor_i (dvs_q),
    .bit_i     (dvd_q[DATA_W-1]),
    .rem_o     (step_rem),
    .q_o       (step_q)
  );

  assign neg1 = signed_div_i & opdata1_i[DATA_W-1];
  assign neg2 = signed_div_i & opdata2_i[DATA_W-1];

`ifdef DIV_ZERO_SHORTCUT_EN
  assign zero_go = (opdata2_i == ZERO_WORD) || (opdata1_i == ZERO_WORD);
`else
  assign zero_go = (opdata2_i == ZERO_WORD);
`endif

  assign stallreq_o = ((state_q == DIV_FREE) & start_i & ~annul_i)
                    | (state_q == DIV_ON)
                    | (state_q == DIV_BY_ZERO);

  assign result_o = result_q;
  assign ready_o  = ready_q;

  // Next-state, iteration and result logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    rem_d    = rem_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    result_d = result_q;
    ready_d  = ready_q;
    unique case (state_q)
      DIV_FREE: begin
        result_d = '0;
        ready_d  = DIV_RESULT_NOT_READY;
        if (start_i == DIV_START && !annul_i) begin
          if (zero_go) begin
            state_d = DIV_BY_ZERO;
          end else begin
            state_d = DIV_ON;
            cnt_d   = '0;
            rem_d   = '0;
            dvd_d   = neg_if(neg1, opdata1_i);
            dvs_d   = neg_if(neg2, opdata2_i);
            negq_d  = neg1 ^ neg2;
            negr_d  = neg1;
          end
        end
      end
      DIV_BY_ZERO: begin
        state_d  = DIV_END;
        result_d = '0;
        ready_d  = DIV_RESULT_READY;
      end
      DIV_ON: begin
        if (annul_i) begin
          state_d  = DIV_FREE;
          result_d = '0;
          ready_d  = DIV_RESULT_NOT_READY;
        end else if (cnt_q != CNT_W'(DATA_W)) begin
          rem_d = step_rem;
          dvd_d = {dvd_q[DATA_W-2:0], step_q};
          cnt_d = cnt_q + 1'b1;
        end else begin
          result_d = {neg_if(negr_q, rem_q), neg_if(negq_q, dvd_q)};
          ready_d  = DIV_RESULT_READY;
          state_d  = DIV_END;
        end
      end
      DIV_END: begin
        if (start_i == DIV_STOP) begin
          state_d  = DIV_FREE;
          result_d = '0;
          ready_d  = DIV_RESULT_NOT_READY;
        end
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= DIV_FREE;
      cnt_q    <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      result_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      rem_q    <= rem_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// Scoreboard bench for div_seq: directed vectors, monitor on ready_o.
// Honours DIV_ZERO_SHORTCUT_EN for zero-dividend latency.
module tb_div_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        signed_div = 1'b0;
  logic        start = 1'b0;
  logic        annul = 1'b0;
  logic [31:0] op1 = '0;
  logic [31:0] op2 = '0;
  logic [63:0] result;
  logic        ready;
  logic        stallreq;

  int n_vec = 0;
  int n_err = 0;

  logic [63:0] sb[$];
  string       nq[$];
  logic        ready_prev = 1'b0;

`ifdef DIV_ZERO_SHORTCUT_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = 33;
`endif

  always #5 clk = ~clk;

  div_seq dut (
    .clk          (clk),
    .rst          (rst_n),
    .signed_div_i (signed_div),
    .opdata1_i    (op1),
    .opdata2_i    (op2),
    .start_i      (start),
    .annul_i      (annul),
    .result_o     (result),
    .ready_o      (ready),
    .stallreq_o   (stallreq)
  );

  function automatic void chk(input string nm,
                              input logic [63:0] act,
                              input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  // Monitor: compare each new result against the scoreboard.
  always @(negedge clk) begin
    if (ready === 1'b1 && ready_prev !== 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected ready", 64'd1, 64'd0);
      end else begin
        chk({nq.pop_front(), " result"}, result, sb.pop_front());
      end
    end
    ready_prev = ready;
  end

  task automatic run_div(input string nm, input logic sg,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input int lat,
                         input int hold);
    int k;
    bit sbad;
    bit hbad;
    k = 0;
    sbad = 0;
    hbad = 0;
    @(negedge clk);
    signed_div = sg;
    op1 = a;
    op2 = b;
    start = 1'b1;
    sb.push_back(exp);
    nq.push_back(nm);
    #1;
    if (stallreq !== 1'b1) sbad = 1;
    @(posedge clk);
    #1;
    while (ready !== 1'b1 && k < 40) begin
      if (stallreq !== 1'b1) sbad = 1;
      @(posedge clk);
      #1;
      k++;
    end
    if (stallreq !== 1'b0) sbad = 1;
    chk({nm, " latency"}, 64'(k), 64'(lat));
    chk({nm, " stall"}, 64'(sbad), 64'd0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      if (ready !== 1'b1 || result !== exp) hbad = 1;
    end
    if (hold > 0) chk({nm, " hold"}, 64'(hbad), 64'd0);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
    chk({nm, " release"}, {63'd0, ready} | result, 64'd0);
  endtask

  initial begin
    bit bad;
    int k;
    #1 rst_n = 1'b0;
    #2;
    chk("reset result", result, 64'd0);
    chk("reset ready/stall", {62'd0, ready, stallreq}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    run_div("u100/7", 1'b0, 32'd100, 32'd7,
            64'h00000002_0000000E, 33, 5);
    run_div("s-7/2", 1'b1, 32'hFFFFFFF9, 32'd2,
            64'hFFFFFFFF_FFFFFFFD, 33, 0);
    run_div("u-7/2", 1'b0, 32'hFFFFFFF9, 32'd2,
            64'h00000001_7FFFFFFC, 33, 0);
    run_div("div0", 1'b0, 32'h12345678, 32'd0,
            64'd0, 1, 2);
    run_div("intmin/-1", 1'b1, 32'h80000000, 32'hFFFFFFFF,
            64'h00000000_80000000, 33, 0);
    run_div("ffff/1", 1'b0, 32'hFFFFFFFF, 32'd1,
            64'h00000000_FFFFFFFF, 33, 0);
    run_div("s7/-2", 1'b1, 32'd7, 32'hFFFFFFFE,
            64'h00000001_FFFFFFFD, 33, 0);
    run_div("s-100/-7", 1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9,
            64'hFFFFFFFE_0000000E, 33, 0);
    run_div("ffff/16", 1'b0, 32'hFFFFFFFF, 32'h10,
            64'h0000000F_0FFFFFFF, 33, 0);
    run_div("u5/9", 1'b0, 32'd5, 32'd9,
            64'h00000005_00000000, 33, 0);
    run_div("zero dividend", 1'b0, 32'd0, 32'd5,
            64'd0, ZLAT, 0);

    // Annul mid-divide.
    @(negedge clk);
    signed_div = 1'b0;
    op1 = 32'd100;
    op2 = 32'd7;
    start = 1'b1;
    @(posedge clk);
    repeat (10) @(posedge clk);
    @(negedge clk);
    annul = 1'b1;
    start = 1'b0;
    @(posedge clk);
    #1;
    chk("annul free", {62'd0, ready, stallreq}, 64'd0);
    @(negedge clk);
    annul = 1'b0;
    bad = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (ready !== 1'b0) bad = 1;
    end
    chk("annul no ready", 64'(bad), 64'd0);
    run_div("u9/3", 1'b0, 32'd9, 32'd3,
            64'h00000000_00000003, 33, 0);

    // Asynchronous reset while iterating.
    @(negedge clk);
    signed_div = 1'b0;
    op1 = 32'd100;
    op2 = 32'd7;
    start = 1'b1;
    repeat (16) @(posedge clk);
    #3;
    rst_n = 1'b0;
    start = 1'b0;
    #1;
    chk("rst in ON ready/stall", {62'd0, ready, stallreq}, 64'd0);
    chk("rst in ON result", result, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("idle after rst", {62'd0, ready, stallreq}, 64'd0);

    // Asynchronous reset while a result is being held.
    @(negedge clk);
    op1 = 32'd1000;
    op2 = 32'd10;
    start = 1'b1;
    sb.push_back(64'h00000000_00000064);
    nq.push_back("u1000/10");
    @(posedge clk);
    #1;
    k = 0;
    while (ready !== 1'b1 && k < 40) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("u1000/10 latency", 64'(k), 64'd33);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    start = 1'b0;
    #1;
    chk("rst in END result", result, 64'd0);
    chk("rst in END ready", {63'd0, ready}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    chk("scoreboard drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
